// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle controller.
// Holds the opcode and ALU function encodings, the FSM state encoding and
// the instruction classes that the opcode decoder reports.
package cpu_defs;

  localparam int unsigned OpcodeWidth = 6;
  // There are eight working states and a halt state, so the state register needs 4 bits.
  localparam int unsigned StateWidth  = 4;

  // Opcodes
  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b000001;
  localparam logic [5:0] OpSub  = 6'b000010;
  localparam logic [5:0] OpOri  = 6'b010000;
  localparam logic [5:0] OpAnd  = 6'b010001;
  localparam logic [5:0] OpOr   = 6'b010010;
  localparam logic [5:0] OpMove = 6'b100000;
  localparam logic [5:0] OpSw   = 6'b100110;
  localparam logic [5:0] OpLw   = 6'b100111;
  localparam logic [5:0] OpBeq  = 6'b110000;
  localparam logic [5:0] OpHalt = 6'b111111;

  // ALU functions
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b100;
  localparam logic [2:0] AluOr  = 3'b101;

  typedef enum logic [StateWidth-1:0] {
    StIf    = 4'b0000,
    StId    = 4'b0001,
    StExeLs = 4'b0010,
    StMem   = 4'b0011,
    StWbLd  = 4'b0100,
    StExeBr = 4'b0101,
    StExeAl = 4'b0110,
    StWbAl  = 4'b0111,
    StHalt  = 4'b1000
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsHalt,
    ClsUndef
  } instr_class_e;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decoder.
// Ports:
//   opcode_i      - opcode field from the instruction register
//   instr_class_o - instruction class (ALU, load, store, branch, halt, undefined)
//   alu_op_o      - ALU function for the execute phase
//   alu_src_b_o   - 0 = ReadData2, 1 = extended immediate
//   ext_sel_o     - 0 = zero-extend, 1 = sign-extend
//   reg_out_o     - 0 = rt, 1 = rd as write register
module opcode_decoder
  import cpu_defs::*;
#(
  parameter int unsigned OPW = OpcodeWidth
) (
  input  logic [OPW-1:0] opcode_i,
  output instr_class_e   instr_class_o,
  output logic [2:0]     alu_op_o,
  output logic           alu_src_b_o,
  output logic           ext_sel_o,
  output logic           reg_out_o
);

  always_comb begin
    instr_class_o = ClsUndef;
    alu_op_o      = AluAdd;
    alu_src_b_o   = 1'b0;
    ext_sel_o     = 1'b0;
    reg_out_o     = 1'b0;
    case (opcode_i)
      // move is rd = rs + $0, so it shares the add datapath
      OpAdd, OpMove: begin
        instr_class_o = ClsAlu;
        reg_out_o     = 1'b1;
      end
      OpSub: begin
        instr_class_o = ClsAlu;
        alu_op_o      = AluSub;
        reg_out_o     = 1'b1;
      end
      OpAnd: begin
        instr_class_o = ClsAlu;
        alu_op_o      = AluAnd;
        reg_out_o     = 1'b1;
      end
      OpOr: begin
        instr_class_o = ClsAlu;
        alu_op_o      = AluOr;
        reg_out_o     = 1'b1;
      end
      OpAddi: begin
        instr_class_o = ClsAlu;
        alu_src_b_o   = 1'b1;
        ext_sel_o     = 1'b1;
      end
      OpOri: begin
        instr_class_o = ClsAlu;
        alu_op_o      = AluOr;
        alu_src_b_o   = 1'b1;
      end
      OpLw: begin
        instr_class_o = ClsLoad;
        alu_src_b_o   = 1'b1;
        ext_sel_o     = 1'b1;
      end
      OpSw: begin
        instr_class_o = ClsStore;
        alu_src_b_o   = 1'b1;
        ext_sel_o     = 1'b1;
      end
      OpBeq: begin
        instr_class_o = ClsBranch;
        alu_op_o      = AluSub;
        ext_sel_o     = 1'b1;
      end
      OpHalt: begin
        instr_class_o = ClsHalt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle controller sequencing the single-cycle datapath through
// IF/ID/EXE/MEM/WB phases. Outputs are combinational from the state register and Opcode.
// Ports:
//   CLK, clrn     - rising-edge clock, synchronous active-low reset
//   Opcode        - opcode field from the instruction register
//   Zero          - ALU zero flag, used in the branch execute phase
//   MemReady      - data memory access done, used in the memory phase
//   PCWre, IRWre, RegWre, DataMemRW - write/load enables
//   ALUSrcB, ALUOp, ALUM2Reg, RegOut, PCSrc, ExtSel - datapath selects
//   State         - current state (debug)
//   Halted        - high while halted
module multicycle_control_unit
  import cpu_defs::*;
#(
  parameter int unsigned OPW = OpcodeWidth,
  parameter int unsigned STW = StateWidth
) (
  input  logic           CLK,
  input  logic           clrn,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  input  logic           MemReady,
  output logic           PCWre,
  output logic           IRWre,
  output logic           RegWre,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           ALUM2Reg,
  output logic           RegOut,
  output logic           DataMemRW,
  output logic           PCSrc,
  output logic           ExtSel,
  output logic [STW-1:0] State,
  output logic           Halted
);

  state_e       state_q, state_d;
  instr_class_e instr_class;
  logic [2:0]   dec_alu_op;
  logic         dec_alu_src_b;
  logic         dec_ext_sel;
  logic         dec_reg_out;

  opcode_decoder #(
    .OPW(OPW)
  ) u_decoder (
    .opcode_i     (Opcode),
    .instr_class_o(instr_class),
    .alu_op_o     (dec_alu_op),
    .alu_src_b_o  (dec_alu_src_b),
    .ext_sel_o    (dec_ext_sel),
    .reg_out_o    (dec_reg_out)
  );

  always_ff @(posedge CLK) begin
    if (!clrn) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIf;
    case (state_q)
      StIf: state_d = StId;
      StId: begin
        case (instr_class)
          ClsAlu:            state_d = StExeAl;
          ClsLoad, ClsStore: state_d = StExeLs;
          ClsBranch:         state_d = StExeBr;
          ClsHalt:           state_d = StHalt;
          default:           state_d = StIf;
        endcase
      end
      StExeAl: state_d = StWbAl;
      StWbAl:  state_d = StIf;
      StExeLs: state_d = StMem;
      StMem: begin
        if (!MemReady) begin
          state_d = StMem;
        end else if (instr_class == ClsLoad) begin
          state_d = StWbLd;
        end else begin
          state_d = StIf;
        end
      end
      StWbLd:  state_d = StIf;
      StExeBr: state_d = StIf;
      StHalt:  state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = AluAdd;
    ALUM2Reg  = 1'b0;
    RegOut    = 1'b0;
    DataMemRW = 1'b0;
    PCSrc     = 1'b0;
    ExtSel    = 1'b0;
    Halted    = 1'b0;
    // Gating on clrn keeps every enable low during reset, even mid-instruction.
    if (clrn) begin
      case (state_q)
        StIf: IRWre = 1'b1;
        StId: begin
          // Undefined opcode: skip it by advancing to PC+4.
          if (instr_class == ClsUndef) begin
            PCWre = 1'b1;
          end
        end
        StExeAl: begin
          ALUOp   = dec_alu_op;
          ALUSrcB = dec_alu_src_b;
          ExtSel  = dec_ext_sel;
        end
        StWbAl: begin
          ALUOp   = dec_alu_op;
          ALUSrcB = dec_alu_src_b;
          ExtSel  = dec_ext_sel;
          RegWre  = 1'b1;
          RegOut  = dec_reg_out;
          PCWre   = 1'b1;
        end
        StExeLs: begin
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
        end
        StMem: begin
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
          if (instr_class == ClsStore) begin
            DataMemRW = 1'b1;
            PCWre     = MemReady;
          end
        end
        StWbLd: begin
          ALUSrcB  = 1'b1;
          ExtSel   = 1'b1;
          RegWre   = 1'b1;
          ALUM2Reg = 1'b1;
          PCWre    = 1'b1;
        end
        StExeBr: begin
          ALUOp  = AluSub;
          ExtSel = 1'b1;
          PCWre  = 1'b1;
          PCSrc  = Zero;
        end
        StHalt: Halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign State = STW'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. A phase-level reference
// model derives the expected state sequence and control outputs per cycle.
module tb_multicycle_control_unit;

  localparam int PhIf    = 0;
  localparam int PhId    = 1;
  localparam int PhExeLs = 2;
  localparam int PhMem   = 3;
  localparam int PhWbLd  = 4;
  localparam int PhExeBr = 5;
  localparam int PhExeAl = 6;
  localparam int PhWbAl  = 7;

  localparam logic [5:0] OAdd  = 6'b000000;
  localparam logic [5:0] OAddi = 6'b000001;
  localparam logic [5:0] OSub  = 6'b000010;
  localparam logic [5:0] OOri  = 6'b010000;
  localparam logic [5:0] OAnd  = 6'b010001;
  localparam logic [5:0] OOr   = 6'b010010;
  localparam logic [5:0] OMove = 6'b100000;
  localparam logic [5:0] OSw   = 6'b100110;
  localparam logic [5:0] OLw   = 6'b100111;
  localparam logic [5:0] OBeq  = 6'b110000;
  localparam logic [5:0] OHalt = 6'b111111;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       reg_wre;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       alu_m2reg;
    logic       reg_out;
    logic       mem_rw;
    logic       pc_src;
    logic       ext_sel;
    logic       halted;
  } ctl_t;

  logic       CLK;
  logic       clrn;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWre, IRWre, RegWre, ALUSrcB, ALUM2Reg, RegOut, DataMemRW, PCSrc, ExtSel;
  logic [2:0] ALUOp;
  logic [3:0] State;
  logic       Halted;
  ctl_t       act;

  int checks;
  int errors;

  multicycle_control_unit dut (
    .CLK      (CLK),
    .clrn     (clrn),
    .Opcode   (Opcode),
    .Zero     (Zero),
    .MemReady (MemReady),
    .PCWre    (PCWre),
    .IRWre    (IRWre),
    .RegWre   (RegWre),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .ALUM2Reg (ALUM2Reg),
    .RegOut   (RegOut),
    .DataMemRW(DataMemRW),
    .PCSrc    (PCSrc),
    .ExtSel   (ExtSel),
    .State    (State),
    .Halted   (Halted)
  );

  assign act = {PCWre, IRWre, RegWre, ALUSrcB, ALUOp, ALUM2Reg, RegOut, DataMemRW, PCSrc,
                ExtSel, Halted};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic bit is_defined(input logic [5:0] op);
    return op inside {OAdd, OAddi, OSub, OOri, OAnd, OOr, OMove, OSw, OLw, OBeq, OHalt};
  endfunction

  function automatic bit is_alu(input logic [5:0] op);
    return op inside {OAdd, OAddi, OSub, OOri, OAnd, OOr, OMove};
  endfunction

  // ALU function, immediate operand and sign-extension for ALU-class instructions.
  function automatic void alu_props(input logic [5:0] op, output logic [2:0] aop,
                                    output logic imm, output logic sext);
    aop = 3'b000;
    imm = 1'b0;
    sext = 1'b0;
    case (op)
      OSub:  aop = 3'b001;
      OAnd:  aop = 3'b100;
      OOr:   aop = 3'b101;
      OAddi: begin imm = 1'b1; sext = 1'b1; end
      OOri:  begin aop = 3'b101; imm = 1'b1; end
      default: ;
    endcase
  endfunction

  // Expected outputs e and the set of fields m that are defined for this phase.
  function automatic void model_cycle(input logic [5:0] op, input int ph, input logic z,
                                      input logic mr, output ctl_t e, output ctl_t m);
    logic [2:0] aop;
    logic       imm, sext;
    e = '0;
    m = '0;
    m.pc_wre = 1'b1; m.ir_wre = 1'b1; m.reg_wre = 1'b1; m.mem_rw = 1'b1; m.halted = 1'b1;
    alu_props(op, aop, imm, sext);
    case (ph)
      PhIf: e.ir_wre = 1'b1;
      PhId: if (!is_defined(op)) begin e.pc_wre = 1'b1; m.pc_src = 1'b1; end
      PhExeAl, PhWbAl: begin
        e.alu_op = aop; e.alu_src_b = imm; m.alu_op = 3'b111; m.alu_src_b = 1'b1;
        if (imm) begin e.ext_sel = sext; m.ext_sel = 1'b1; end
        if (ph == PhWbAl) begin
          e.reg_wre = 1'b1; e.reg_out = !imm; e.pc_wre = 1'b1;
          m.reg_out = 1'b1; m.alu_m2reg = 1'b1; m.pc_src = 1'b1;
        end
      end
      PhExeLs, PhMem: begin
        e.alu_src_b = 1'b1; e.ext_sel = 1'b1;
        m.alu_op = 3'b111; m.alu_src_b = 1'b1; m.ext_sel = 1'b1;
        if (ph == PhMem) begin
          e.mem_rw = (op == OSw);
          if (op == OSw && mr) begin e.pc_wre = 1'b1; m.pc_src = 1'b1; end
        end
      end
      PhWbLd: begin
        e.reg_wre = 1'b1; e.alu_m2reg = 1'b1; e.pc_wre = 1'b1;
        m.reg_out = 1'b1; m.alu_m2reg = 1'b1; m.pc_src = 1'b1;
      end
      PhExeBr: begin
        e.alu_op = 3'b001; e.ext_sel = 1'b1; e.pc_wre = 1'b1; e.pc_src = z;
        m.alu_op = 3'b111; m.alu_src_b = 1'b1; m.ext_sel = 1'b1; m.pc_src = 1'b1;
      end
      default: ;
    endcase
  endfunction

  // Runs one instruction from IF; w = number of MemReady=0 cycles in the memory phase.
  task automatic exec_instr(input logic [5:0] op, input logic z, input int w, input string tag);
    int   phases[$];
    int   memk;
    ctl_t e, m;
    logic mr;
    memk = 0;
    phases.push_back(PhIf);
    phases.push_back(PhId);
    if (is_alu(op)) begin
      phases.push_back(PhExeAl);
      phases.push_back(PhWbAl);
    end else if (op == OLw || op == OSw) begin
      phases.push_back(PhExeLs);
      for (int k = 0; k <= w; k++) phases.push_back(PhMem);
      if (op == OLw) phases.push_back(PhWbLd);
    end else if (op == OBeq) begin
      phases.push_back(PhExeBr);
    end
    foreach (phases[i]) begin
      Opcode = op;
      Zero = (phases[i] == PhExeBr) ? z : 1'($urandom);
      if (phases[i] == PhMem) begin
        mr = (memk >= w);
        memk++;
      end else begin
        mr = 1'($urandom);
      end
      MemReady = mr;
      #1;
      checks++;
      if (State !== 4'(phases[i])) begin
        errors++;
        $display("FAIL %s state cycle %0d: got %0d want %0d", tag, i, State, phases[i]);
      end
      model_cycle(op, phases[i], z, mr, e, m);
      checks++;
      if (((act ^ e) & m) !== '0) begin
        errors++;
        $display("FAIL %s outputs cycle %0d phase %0d: got %b want %b mask %b",
                 tag, i, phases[i], act, e, m);
      end
      @(posedge CLK);
      #1;
    end
    checks++;
    if (State !== 4'(PhIf)) begin
      errors++;
      $display("FAIL %s return to IF after %0d cycles: got %0d want %0d",
               tag, phases.size(), State, PhIf);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    Opcode = 6'b101010;
    Zero = 1'b1;
    MemReady = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (State !== 4'(PhIf)) begin
      errors++;
      $display("FAIL reset state: got %0d want %0d", State, PhIf);
    end
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %b want all zero", act);
    end
    clrn = 1'b1;
    #1;
    checks++;
    if (IRWre !== 1'b1) begin
      errors++;
      $display("FAIL reset release IRWre: got %b want 1", IRWre);
    end
  endtask

  task automatic test_add();
    exec_instr(OAdd, 1'b0, 0, "add");
  endtask

  task automatic test_alu_ops();
    logic [5:0] ops[6];
    ops = '{OAddi, OSub, OOri, OAnd, OOr, OMove};
    foreach (ops[i]) exec_instr(ops[i], 1'($urandom), 0, "alu_op");
  endtask

  task automatic test_lw_wait();
    exec_instr(OLw, 1'b0, 2, "lw_wait");
  endtask

  task automatic test_sw();
    exec_instr(OSw, 1'b0, 0, "sw_fast");
    exec_instr(OSw, 1'b0, 3, "sw_wait");
  endtask

  task automatic test_beq();
    exec_instr(OBeq, 1'b1, 0, "beq_taken");
    exec_instr(OBeq, 1'b0, 0, "beq_not_taken");
  endtask

  task automatic test_undefined();
    exec_instr(6'b101010, 1'b0, 0, "undefined");
  endtask

  task automatic test_random();
    logic [5:0] pool[10];
    logic [5:0] op;
    pool = '{OAdd, OAddi, OSub, OOri, OAnd, OOr, OMove, OSw, OLw, OBeq};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        do op = 6'($urandom); while (is_defined(op));
      end else begin
        op = pool[$urandom_range(0, 9)];
      end
      exec_instr(op, 1'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_reset_mid_lw();
    Opcode = OLw;
    MemReady = 1'b0;
    Zero = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    checks++;
    if (State !== 4'(PhMem)) begin
      errors++;
      $display("FAIL reset_mid_lw reach MEM: got %0d want %0d", State, PhMem);
    end
    clrn = 1'b0;
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_mid_lw forced outputs: got %b want all zero", act);
    end
    for (int k = 0; k < 2; k++) begin
      MemReady = 1'($urandom);
      @(posedge CLK);
      #1;
      checks++;
      if (State !== 4'(PhIf)) begin
        errors++;
        $display("FAIL reset_mid_lw state edge %0d: got %0d want %0d", k, State, PhIf);
      end
      checks++;
      if (act !== '0) begin
        errors++;
        $display("FAIL reset_mid_lw outputs edge %0d: got %b want all zero", k, act);
      end
    end
    clrn = 1'b1;
    MemReady = 1'b1;
    #1;
    checks++;
    if ({State, IRWre, RegWre, PCWre} !== {4'(PhIf), 3'b100}) begin
      errors++;
      $display("FAIL reset_mid_lw release: got state %0d IRWre %b RegWre %b PCWre %b want 0 1 0 0",
               State, IRWre, RegWre, PCWre);
    end
  endtask

  task automatic test_halt();
    logic [3:0] hs;
    Opcode = OHalt;
    @(posedge CLK);
    #1;
    checks++;
    if (State !== 4'(PhId) || act !== '0) begin
      errors++;
      $display("FAIL halt decode: got state %0d outputs %b want %0d all zero", State, act, PhId);
    end
    @(posedge CLK);
    #1;
    hs = State;
    checks++;
    if (Halted !== 1'b1 || hs < 4'd8) begin
      errors++;
      $display("FAIL halt entry: got Halted %b state %0d want 1 and a distinct code", Halted, hs);
    end
    for (int k = 0; k < 20; k++) begin
      Opcode = 6'($urandom);
      Zero = 1'($urandom);
      MemReady = 1'($urandom);
      @(posedge CLK);
      #1;
      checks++;
      if (State !== hs || {PCWre, IRWre, RegWre, DataMemRW, Halted} !== 5'b00001) begin
        errors++;
        $display("FAIL halt hold cycle %0d: got state %0d enables %b want %0d 00001", k, State,
                 {PCWre, IRWre, RegWre, DataMemRW, Halted}, hs);
      end
    end
    clrn = 1'b0;
    @(posedge CLK);
    #1;
    clrn = 1'b1;
    #1;
    checks++;
    if (State !== 4'(PhIf) || Halted !== 1'b0) begin
      errors++;
      $display("FAIL halt exit: got state %0d Halted %b want %0d 0", State, Halted, PhIf);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_alu_ops();
    test_lw_wait();
    test_sw();
    test_beq();
    test_undefined();
    test_random();
    test_reset_mid_lw();
    test_add();
    test_halt();
    exec_instr(OLw, 1'b0, 1, "after_halt");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle controller that sequences the existing single-cycle datapath (PC, InsMemory, Regfile, Extend, ALU, DataMemory, and the 2:1 muxes) as a five-phase IF/ID/EXE/MEM/WB machine. It adds an instruction-register write strobe and a data-memory ready handshake. It is a drop-in replacement for ControlUnit: same control-output names and meanings, plus state sequencing.

Parameters:
OPW, 6, opcode width
STW, 3, state-register width

Ports:
CLK  input  1  rising-edge clock
clrn  input  1  reset; synchronous, active-low
Opcode  input  OPW  opcode field from the instruction register
Zero  input  1  ALU zero flag, sampled in sEXE_BR
MemReady  input  1  data memory access done; sampled in sMEM
PCWre  output  1  PC load enable
IRWre  output  1  instruction-register load enable
RegWre  output  1  Regfile write enable
ALUSrcB  output  1  0=ReadData2, 1=extended immediate
ALUOp  output  3  ALU function
ALUM2Reg  output  1  0=ALU result, 1=DataMemory out to WriteData
RegOut  output  1  0=rt, 1=rd as WriteReg
DataMemRW  output  1  1=write DataMemory
PCSrc  output  1  0=PC+4, 1=branch target
ExtSel  output  1  0=zero-extend, 1=sign-extend
State  output  STW  current state, for debug/bench
Halted  output  1  1 while in sHALT

Behaviour:
- Reset: if clrn=0 at a CLK edge, then State<=sIF. While clrn=0, PCWre, IRWre, RegWre, DataMemRW and Halted are forced to 0, and all selects are forced to 0. Reset mid-instruction aborts the instruction; no partial write occurs after the reset edge.
- Outputs are combinational from the state register and Opcode (Moore plus decode). There are no registered outputs.
- sIF(000): IRWre=1 -> sID.
- sID(001): decode Opcode.
  - R-type/ALU-imm (add, sub, addi, ori, and, or, move) -> sEXE_AL.
  - sw/lw -> sEXE_LS.
  - beq -> sEXE_BR.
  - halt -> sHALT.
  - Undefined opcode: PCWre=1, PCSrc=0 (skip) -> sIF.
- sEXE_AL(110): ALUOp/ALUSrcB/ExtSel per opcode -> sWB_AL.
- sWB_AL(111): RegWre=1; RegOut=1 for R-type, 0 for immediate forms; ALUM2Reg=0; PCWre=1 -> sIF. ALU controls are held from sEXE_AL.
- sEXE_LS(010): ALUOp=ADD, ALUSrcB=1, ExtSel=1 -> sMEM.
- sMEM(011): ALU controls held.
  - sw: DataMemRW=1 for every cycle in sMEM. When MemReady=1: PCWre=1 -> sIF.
  - lw: DataMemRW=0; when MemReady=1 -> sWB_LD.
  - While MemReady=0, stay in sMEM with no state change and no PCWre.
- sWB_LD(100): RegWre=1, RegOut=0, ALUM2Reg=1, PCWre=1 -> sIF.
- sEXE_BR(101): ALUOp=SUB, ALUSrcB=0, ExtSel=1, PCWre=1, PCSrc=Zero -> sIF.
- sHALT: Halted=1; all enables 0. Only reset exits.
- Any unused state code -> sIF on the next edge, with outputs 0.
- Latency with MemReady=1 on first sample: R/imm 4 cycles, lw 5, sw 4, beq 3. Each MemReady=0 cycle adds 1.
- ExtSel: 1 for addi/lw/sw/beq; 0 for ori.
- ALUOp in sEXE_AL: add/addi/move=ADD, sub=SUB, and=AND, or/ori=OR.
- RegWre and PCWre are never asserted together with IRWre.

Decomposition:
- Shared package cpu_defs holds:
  - opcode constants: ADD 000000, ADDI 000001, SUB 000010, ORI 010000, AND 010001, OR 010010, MOVE 100000, SW 100110, LW 100111, BEQ 110000, HALT 111111;
  - ALUOp constants: ADD 000, SUB 001, AND 100, OR 101;
  - state encodings. sHALT uses a distinct code; STW is widened to 4 if sHALT needs a code beyond 3 bits.
- One natural sub-module, opcode_decoder (combinational): maps Opcode to instruction class, ALUOp, ALUSrcB, ExtSel and RegOut. The FSM gates these with state.

Test Plan:
- clrn=0 for 2 edges mid-lw (in sMEM) -> State=sIF, DataMemRW=0, RegWre=0, PCWre=0; no Regfile write observed.
- add (000000), MemReady=1 -> States IF,ID,EXE_AL,WB_AL. RegWre=1, RegOut=1, PCWre=1 only in WB_AL. IRWre=1 only in IF. Total 4 cycles.
- lw (100111) with MemReady low for 2 cycles -> 3 cycles in sMEM, then sWB_LD with RegWre=1, ALUM2Reg=1. Total 7 cycles; DataMemRW=0 throughout.
- sw (100110) -> DataMemRW=1 for every sMEM cycle; PCWre=1 in the cycle MemReady=1; RegWre never 1.
- beq with Zero=1, then with Zero=0 -> 3 cycles each; sEXE_BR has PCWre=1, ALUOp=001, and PCSrc=1 and 0 respectively.
- halt (111111) -> after sID, Halted=1 and State is constant for 20 cycles with all enables 0. Undefined opcode 101010 -> sID asserts PCWre=1, PCSrc=0, then returns to sIF.
